copy_fork_n: RTL and testbench
==============================

# copy_fork_n

Clocked, parametrised successor to the two-way CSP copy stage: it accepts tokens on one valid/ready input and delivers each token to a per-token subset of `NUM_OUT` outputs, with an input FIFO of `DEPTH` entries for decoupling. Outputs handshake independently (eager fork), so a stalled consumer never blocks delivery to the others for the current token. It sits between a PE producer and multiple consumers (e.g., the partial-sum and forwarding paths) in the synchronous PE datapath. An optional compile-time feature primes every output with one zero token at reset.

## Interface
- `WIDTH`, 8, data bits per token.
- `NUM_OUT`, 2, number of output channels (2..16).
- `DEPTH`, 4, input FIFO entries; power of two, >= 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `in_valid`  input  1  producer has a token.
- `in_ready`  output  1  FIFO can accept a token.
- `in_data`  input  WIDTH  token payload.
- `in_mask`  input  NUM_OUT  destination set; bit i set means deliver to output i.
- `out_valid`  output  NUM_OUT  per-output token available.
- `out_ready`  input  NUM_OUT  per-output consumer acceptance.
- `out_data`  output  WIDTH  head-token payload, shared by all outputs.
- `occupancy`  output  $clog2(DEPTH)+1  entries currently stored.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `{in_mask, in_data}` at the tail.
- The head entry is broadcast on `out_data`. The `pending[NUM_OUT]` register is loaded with the head mask whenever a new entry becomes head.
- `out_valid[i] = !empty && pending[i]`.
- A handshake on output i (`out_valid[i] && out_ready[i]`) clears `pending[i]`. Multiple outputs may handshake in the same cycle.
- Pop: the head is popped in the cycle where `pending & ~(out_valid & out_ready)` becomes zero. The next entry, if any, becomes head with its mask loaded into `pending` on the same edge (no bubble).
- Mask zero: the entry pops on the first cycle it is head, with no `out_valid` asserted, and costs 1 cycle.
- Push and pop in the same cycle are both honoured. Occupancy is unchanged in that case.
- Tokens are delivered in FIFO order on every output. An output never sees token k+1 before token k has completed on all of its destinations.

## Timing
- Reset, sampled when `rst_n`=0 at a rising edge:
  - FIFO is emptied (or primed; see Configuration).
  - Outputs become: `pending`=0, `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=1.
- Reset mid-operation discards all stored and partially delivered tokens. There is no completion of in-flight tokens.
- `in_ready = (occupancy != DEPTH)`. It is registered-state only and does not depend on the same-cycle pop, so there is no combinational path from `out_ready` to `in_ready`.
- Latency: a token pushed at edge t into an empty FIFO drives `out_valid` in the cycle after edge t, i.e., 1 cycle.
- Throughput: 1 token per cycle when all destination consumers hold `out_ready`=1.
- `out_valid[i]`, once asserted, stays high with `out_data` stable until handshake or reset.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Full/empty are derived from `occupancy`. Push is refused when full. Pop never occurs when empty.

## Configuration
- `COPY_FORK_INIT_TOKEN_EN` defined:
  - Reset leaves one entry `{all-ones mask, zero data}` in the FIFO.
  - After reset: `occupancy`=1, `out_valid`=all ones, `out_data`=0, `pending`=all ones.
  - This entry breaks cyclic-dependency deadlock in feedback rings.
- Undefined: reset leaves the FIFO empty, as specified under Timing.

## Test plan
- Broadcast: NUM_OUT=2. Push 0x11, 0x22, 0x33 with mask 2'b11 and both `out_ready`=1 -> each output receives 0x11, 0x22, 0x33 on 3 consecutive cycles starting 1 cycle after the first push.
- Eager fork: hold `out_ready[1]`=0 and push 0xA5 with mask 11 -> output 0 takes 0xA5 once and then `out_valid[0]`=0. Release `out_ready[1]` after 5 cycles -> output 1 takes 0xA5, the head pops, and the next token appears on both outputs.
- Multicast/drop: push 0x01 with mask 01, then 0x02 with mask 00, then 0x03 with mask 10 -> output 0 sees only 0x01, output 1 sees only 0x03, and 0x02 never appears.
- Full/wrap: DEPTH=4 with all `out_ready`=0. Push 5 tokens -> `in_ready`=0 after the 4th and `occupancy`=4. Drain and refill for 3 cycles -> order preserved across pointer wrap.
- Reset mid-operation: with 3 tokens stored and one output partially served, assert `rst_n`=0 for 1 edge -> `occupancy`=0 and `out_valid`=0, and no old token reappears.
- With `COPY_FORK_INIT_TOKEN_EN` defined: after reset -> `out_valid`=all ones and `out_data`=0. Accepting on all outputs -> `occupancy` goes to 0.

Source files
------------

// File: rtl/copy_fork_n.sv
// copy_fork_n: eager N-way fork with an input FIFO.
// Each token carries a destination mask; every selected output handshakes
// independently and the head entry pops once all of its destinations have
// taken it. The next entry's mask is loaded on the same edge, so there is no bubble.
// Optional feature macro: COPY_FORK_INIT_TOKEN_EN. When it is defined, reset
// leaves one {all-ones mask, zero data} token in the FIFO so that feedback rings can start.
//
// Handshake semantics: a transfer happens on a rising edge where valid && ready.
// Once a producer raises valid, it holds valid and its payload stable until the transfer.
// in_ready and out_valid are functions of registered state only.
module copy_fork_n #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [NUM_OUT-1:0]         in_mask,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = NUM_OUT + WIDTH;

  // Storage: each entry is {mask, data}
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [NUM_OUT-1:0] pending_q, pending_d;

  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [NUM_OUT-1:0] hs;
  logic [EW-1:0]      head;
  logic [EW-1:0]      next_head;

  // Status, handshakes and output drive, derived from registered state
  always_comb begin
    empty     = (occ_q == '0);
    full      = (occ_q == OW'(DEPTH));
    head      = mem_q[rd_ptr_q];
    next_head = mem_q[rd_ptr_q + PW'(1)];
    out_valid = empty ? '0 : pending_q;
    out_data  = empty ? '0 : head[WIDTH-1:0];
    in_ready  = !full;
    occupancy = occ_q;
    hs        = out_valid & out_ready;
    push      = in_valid && !full;
    // The head retires once no destination remains outstanding after this cycle's handshakes.
    // A zero mask therefore retires on its first head cycle.
    pop       = !empty && ((pending_q & ~hs) == '0);
  end

  // Next-state: storage write, pointers, occupancy and pending-destination set
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_mask, in_data};

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    pending_d = pending_q & ~hs;
    if (pop) begin
      // The entry behind the head becomes the new head. If the head was the only
      // entry, the token being pushed in this cycle becomes the new head instead.
      if (occ_q > OW'(1))  pending_d = next_head[EW-1:WIDTH];
      else if (push)       pending_d = in_mask;
      else                 pending_d = '0;
    end else if (empty) begin
      pending_d = push ? in_mask : '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
`ifdef COPY_FORK_INIT_TOKEN_EN
      mem_q[0]  <= {{NUM_OUT{1'b1}}, {WIDTH{1'b0}}};
      wr_ptr_q  <= PW'(1);
      occ_q     <= OW'(1);
      pending_q <= '1;
`else
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      pending_q <= '0;
`endif
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_copy_fork_n.sv
// Directed bench for copy_fork_n with the default parameters (WIDTH=8, NUM_OUT=2, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_copy_fork_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mask;
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  copy_fork_n #(.WIDTH(8), .NUM_OUT(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = '0;
    step(); step();
    rst_n = 1'b1;
`ifdef COPY_FORK_INIT_TOKEN_EN
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL rst_occ got=%0d exp=1", occupancy); end
    n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL rst_valid got=%b exp=11", out_valid); end
`else
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL rst_valid got=%b exp=00", out_valid); end
`endif
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

`ifdef COPY_FORK_INIT_TOKEN_EN
  // The primed zero token is consumed by both outputs in one cycle
  task automatic test_init_token();
    out_ready = 2'b11;
    step();
    out_ready = 2'b00;
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL init_drain_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL init_drain_valid got=%b exp=00", out_valid); end
  endtask
`endif

  task automatic test_broadcast();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 2'b11; in_mask = 2'b11; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = vals[k];
      step();
      n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL bcast_valid%0d got=%b exp=11", k, out_valid); end
      n_cmp++; if (out_data !== vals[k]) begin n_err++; $display("FAIL bcast_data%0d got=%h exp=%h", k, out_data, vals[k]); end
      n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL bcast_occ%0d got=%0d exp=1", k, occupancy); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL bcast_end_valid got=%b exp=00", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bcast_end_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_eager_fork();
    out_ready = 2'b01; in_mask = 2'b11; in_valid = 1'b1; in_data = 8'hA5;
    step();
    n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL eager_first_valid got=%b exp=11", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL eager_first_data got=%h exp=a5", out_data); end
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 2'b10) begin n_err++; $display("FAIL eager_hold_valid%0d got=%b exp=10", k, out_valid); end
      n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL eager_hold_data%0d got=%h exp=a5", k, out_data); end
      if (k < 4) step();
    end
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL eager_occ got=%0d exp=2", occupancy); end
    out_ready = 2'b11;
    step();
    n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL eager_next_valid got=%b exp=11", out_valid); end
    n_cmp++; if (out_data !== 8'h5A) begin n_err++; $display("FAIL eager_next_data got=%h exp=5a", out_data); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL eager_next_occ got=%0d exp=1", occupancy); end
    step();
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL eager_end_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_multicast_drop();
    out_ready = 2'b11; in_valid = 1'b1;
    in_data = 8'h01; in_mask = 2'b01;
    step();
    n_cmp++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL mc_v1 got=%b exp=01", out_valid); end
    n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL mc_d1 got=%h exp=01", out_data); end
    in_data = 8'h02; in_mask = 2'b00;
    step();
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL mc_v2 got=%b exp=00", out_valid); end
    in_data = 8'h03; in_mask = 2'b10;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 2'b10) begin n_err++; $display("FAIL mc_v3 got=%b exp=10", out_valid); end
    n_cmp++; if (out_data !== 8'h03) begin n_err++; $display("FAIL mc_d3 got=%h exp=03", out_data); end
    step();
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL mc_end_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_full_wrap();
    int idx;
    int delivered;
    int cyc;
    out_ready = 2'b00; in_mask = 2'b11; in_valid = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      in_data = 8'h40 + 8'(k);
      n_cmp++;
      if (in_ready !== (k < 4)) begin n_err++; $display("FAIL full_in_ready%0d got=%b exp=%b", k, in_ready, (k < 4)); end
      if (k < 4) exp_q.push_back(8'h40 + 8'(k));
      step();
    end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready_end got=%b exp=0", in_ready); end
    // Drain while refilling 0x50..0x52 across the pointer wrap
    out_ready = 2'b11;
    idx = 0; delivered = 0; cyc = 0;
    while (cyc < 30 && !(idx == 3 && exp_q.size() == 0 && occupancy == 3'd0)) begin
      if (out_valid == 2'b11 && exp_q.size() > 0) begin
        n_cmp++;
        if (out_data !== exp_q[0]) begin n_err++; $display("FAIL wrap_order%0d got=%h exp=%h", delivered, out_data, exp_q[0]); end
        void'(exp_q.pop_front());
        delivered++;
      end
      in_valid = (idx < 3);
      in_data  = 8'h50 + 8'(idx);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        idx++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (delivered !== 7) begin n_err++; $display("FAIL wrap_count got=%0d exp=7", delivered); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL wrap_end_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 2'b00; in_mask = 2'b11; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h61 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    out_ready = 2'b01;
    step();
    n_cmp++; if (out_valid !== 2'b10) begin n_err++; $display("FAIL rmid_partial got=%b exp=10", out_valid); end
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL rmid_occ_pre got=%0d exp=3", occupancy); end
    out_ready = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef COPY_FORK_INIT_TOKEN_EN
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL rmid_occ got=%0d exp=1", occupancy); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got=%h exp=00", out_data); end
    out_ready = 2'b11;
    step();
`endif
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_occ_post got=%0d exp=0", occupancy); end
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL rmid_valid got=%b exp=00", out_valid); end
    out_ready = 2'b11; in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h77) begin n_err++; $display("FAIL rmid_new_data got=%h exp=77", out_data); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL rmid_new_occ got=%0d exp=1", occupancy); end
    step();
    n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL rmid_no_stale got=%b exp=00", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_end_occ got=%0d exp=0", occupancy); end
  endtask

  initial begin
    test_reset();
`ifdef COPY_FORK_INIT_TOKEN_EN
    test_init_token();
`endif
    test_broadcast();
    test_eager_fork();
    test_multicast_drop();
    test_full_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
